axi_read_burst_ctrl: RTL and testbench
======================================

Name: axi_read_burst_ctrl

Overview:
Sequencer between the slave-side read-address FIFO and the slave's memory/peripheral port. It pops one queued AR entry, walks the burst beat by beat (FIXED/INCR/WRAP address generation), and issues one single-word memory read per beat. It returns each beat on the AXI R channel with RID, RRESP and RLAST, and supplies the running beat count to the FIFO side.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; bytes per beat = DATA_W/8
ID_W, 6, transaction ID width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  AR FIFO has no entry
fifo_pop  out  1  one-cycle pop strobe to AR FIFO
fifo_addr  in  ADDR_W  head-entry start address (show-ahead, valid while !fifo_empty)
fifo_id  in  ID_W  head-entry ID
fifo_len  in  8  head-entry ARLEN (beats-1)
fifo_size  in  3  head-entry ARSIZE
fifo_burst  in  2  head-entry ARBURST
fifo_prot  in  3  head-entry ARPROT
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  ADDR_W  memory read address
mem_prot  out  3  latched ARPROT
mem_ack  in  1  read complete; mem_rdata/mem_err valid this cycle
mem_rdata  in  DATA_W  read data
mem_err  in  1  access error
RVALID  out  1  R beat valid
RREADY  in  1  master accepts beat
RDATA  out  DATA_W  beat data
RRESP  out  2  00 OKAY, 10 SLVERR
RID  out  ID_W  latched transaction ID
RLAST  out  1  final beat of burst
beat_count  out  8  index of current beat, 0..len
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, high): state=IDLE. fifo_pop, mem_req, RVALID, RLAST, busy = 0. mem_addr, mem_prot, RDATA, RRESP, RID, beat_count = 0.
- FSM IDLE -> REQ -> RESP -> (REQ | IDLE).
- IDLE: when !fifo_empty, assert fifo_pop for exactly one cycle. In the same edge, latch addr/id/len/size/burst/prot, set beat_count=0 and go to REQ. Otherwise stay.
- REQ: mem_req=1; mem_addr=cur_addr, stable until mem_ack. On mem_ack, register mem_rdata into RDATA and RRESP = mem_err ? 10 : 00, then go to RESP.
- Error entry (burst=11, WRAP with len not in {1,3,7,15}, or size > log2(DATA_W/8)): REQ issues no mem_req. The FSM goes to RESP next cycle with RDATA=0, RRESP=10. This applies to every beat of the burst.
- RESP: RVALID=1. RLAST=(beat_count==len). RDATA/RRESP/RID/RLAST are held stable until RREADY.
  - On RREADY with RLAST: go to IDLE; RVALID and RLAST drop next cycle.
  - On RREADY without RLAST: beat_count+1, cur_addr=next_addr, go to REQ.
- Address step inc = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr+inc, modulo 2^ADDR_W.
  - WRAP (10): bound=(len+1)*inc; next = (addr & ~(bound-1)) | ((addr+inc) & (bound-1)).
- Latency:
  - !fifo_empty in IDLE -> mem_req: 1 cycle after pop.
  - mem_ack -> RVALID: next cycle.
  - RREADY (non-last) -> next mem_req: next cycle.
  - Last RREADY -> next pop: earliest next cycle (1 idle cycle between bursts).
- fifo_pop is never asserted outside IDLE and never while fifo_empty.
- len=0: single beat; RLAST=1 on the first RESP.
- len=255: beat_count reaches 255 without overflow; RLAST is asserted on beat 255.
- mem_ack outside REQ is ignored.
- Reset mid-burst aborts immediately. The popped entry is discarded; no RLAST is emitted.

Decomposition:
- Package axi_rd_pkg:
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state enum {ST_IDLE, ST_REQ, ST_RESP}
- Sub-module axi_burst_addr_gen: combinational. Inputs cur_addr, size, len, burst. Outputs next_addr and illegal flag. Verified standalone.

Test Plan:
- INCR len=3 size=2 addr=0x1000, mem_rdata=beat index, RREADY=1 -> mem_addr 0x1000,0x1004,0x1008,0x100C; RDATA 0..3; RLAST only on beat 3; RRESP=00.
- WRAP len=3 size=2 addr=0x2008 -> mem_addr 0x2008,0x200C,0x2000,0x2004; RLAST on 4th beat.
- FIXED len=2 addr=0x3000 with RREADY low for 3 cycles on beat 1 -> RVALID/RDATA/beat_count held stable; mem_addr 0x3000 for all 3 beats; no extra mem_req while stalled.
- burst=11 len=1 -> no mem_req; 2 beats with RRESP=10, RDATA=0, RLAST on beat 1; mem_err=1 on an INCR beat -> that beat RRESP=10, the others 00.
- Two queued entries (ID 5 len=0, ID 9 len=1) -> exactly 2 fifo_pop pulses, 1 idle cycle between bursts; RID 5 then 9,9; len=255 burst -> 256 beats, beat_count ends at 255.
- reset asserted during REQ of beat 2 -> all outputs 0 asynchronously; after release with fifo_empty=1, FSM stays in IDLE with no pop.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared encodings and FSM state type for the AXI read-burst sequencer.
package axi_rd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus a flag
// for burst encodings this slave cannot serve.
module axi_burst_addr_gen
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] i_cur_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_illegal
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_sum;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic              w_wrap_len_ok;

    // The wrap window is (len+1) beats of 2^size bytes, always a power of two
    // when the length is legal, so the mask is simply window-1.
    assign w_inc         = ADDR_W'(1) << i_size;
    assign w_sum         = i_cur_addr + w_inc;
    assign w_wrap_mask   = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    assign w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) ||
                           (i_len == 8'd7) || (i_len == 8'd15);

    assign o_illegal = (i_burst == 2'b11) ||
                       ((i_burst == BURST_WRAP) && !w_wrap_len_ok) ||
                       (i_size > 3'(MAX_SIZE));

    always_comb begin
        o_next_addr = i_cur_addr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_cur_addr;
            BURST_INCR:  o_next_addr = w_sum;
            BURST_WRAP:  o_next_addr = (i_cur_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
            default:     o_next_addr = i_cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_burst_ctrl.sv
// Pops one AR entry, walks its beats through single-word memory reads and
// returns each beat on the AXI R channel with RID/RRESP/RLAST.
module axi_read_burst_ctrl
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [ADDR_W-1:0] fifo_addr,
    input  logic [ID_W-1:0]   fifo_id,
    input  logic [7:0]        fifo_len,
    input  logic [2:0]        fifo_size,
    input  logic [1:0]        fifo_burst,
    input  logic [2:0]        fifo_prot,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_prot,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic [ID_W-1:0]   RID,
    output logic              RLAST,
    output logic [7:0]        beat_count,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [2:0]        r_prot;
    logic [7:0]        r_beat;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_illegal;
    logic              w_last;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .i_cur_addr  (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_illegal   (w_illegal)
    );

    assign w_last = (r_beat == r_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Illegal bursts skip the memory and answer every beat with SLVERR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (!fifo_empty) w_next_state = ST_REQ;
            ST_REQ:  if (w_illegal || mem_ack) w_next_state = ST_RESP;
            ST_RESP: if (RREADY) w_next_state = w_last ? ST_IDLE : ST_REQ;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_addr  <= fifo_addr;
                        r_id    <= fifo_id;
                        r_len   <= fifo_len;
                        r_size  <= fifo_size;
                        r_burst <= fifo_burst;
                        r_prot  <= fifo_prot;
                        r_beat  <= '0;
                    end
                end
                ST_REQ: begin
                    if (w_illegal) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end else if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_rresp <= mem_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                ST_RESP: begin
                    if (RREADY && !w_last) begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // The pop is gated by reset so the FIFO never loses an entry while held in reset.
    assign fifo_pop   = (r_state == ST_IDLE) && !fifo_empty && !reset;
    assign mem_req    = (r_state == ST_REQ) && !w_illegal;
    assign mem_addr   = r_addr;
    assign mem_prot   = r_prot;
    assign RVALID     = (r_state == ST_RESP);
    assign RLAST      = (r_state == ST_RESP) && w_last;
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign RID        = r_id;
    assign beat_count = r_beat;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Scoreboard bench for axi_read_burst_ctrl: a FIFO model, a memory model and
// an R-channel monitor compare every beat against expectations queued at push time.
module tb_axi_read_burst_ctrl;
    import axi_rd_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 6;
    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ADDR_W-1:0] fifo_addr;
    logic [ID_W-1:0]   fifo_id;
    logic [7:0]        fifo_len;
    logic [2:0]        fifo_size;
    logic [1:0]        fifo_burst;
    logic [2:0]        fifo_prot;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_prot;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic [ID_W-1:0]   RID;
    logic              RLAST;
    logic [7:0]        beat_count;
    logic              busy;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
        bit          illegal;
    } entry_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [5:0]  id;
        logic        last;
        logic [7:0]  beat;
    } rbeat_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
    } mreq_t;

    entry_t      fifoQ[$];
    rbeat_t      expR[$];
    mreq_t       expMem[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          popCount = 0;
    int          memReqCount = 0;
    int          popCyc = 0;
    int          lastHsCyc = 0;
    int          memLat = 0;
    int          waitCnt = 0;
    int          stallBeat = -1;
    int          stallLeft = 0;
    bit          popPending = 1'b0;
    bit          reqCheck = 1'b0;
    bit          reqCheckLegal = 1'b0;
    bit          gapCheck = 1'b0;
    bit          spuriousAck = 1'b0;
    bit          snapValid = 1'b0;
    logic [31:0] snapData;
    logic [7:0]  snapBeat;
    logic [1:0]  snapResp;
    logic [31:0] errAddr = 32'hFFFF_FFFF;

    axi_read_burst_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_addr  (fifo_addr),
        .fifo_id    (fifo_id),
        .fifo_len   (fifo_len),
        .fifo_size  (fifo_size),
        .fifo_burst (fifo_burst),
        .fifo_prot  (fifo_prot),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_prot   (mem_prot),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RID        (RID),
        .RLAST      (RLAST),
        .beat_count (beat_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic bit isIllegal(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
        bit badWrap;
        badWrap = (burst == 2'b10) && (len != 8'd1) && (len != 8'd3) &&
                  (len != 8'd7) && (len != 8'd15);
        return (burst == 2'b11) || badWrap || (size > 3'd2);
    endfunction

    // Reference address model written with modulo arithmetic on the wrap window.
    function automatic logic [31:0] modelNext(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] inc;
        logic [31:0] bound;
        logic [31:0] off;
        inc = 32'd1 << size;
        if (burst == 2'b01) return addr + inc;
        if (burst == 2'b10) begin
            bound = (32'(len) + 32'd1) * inc;
            off   = addr % bound;
            return (addr - off) + ((off + inc) % bound);
        end
        return addr;
    endfunction

    task automatic pushEntry(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
        entry_t      e;
        rbeat_t      r;
        mreq_t       m;
        logic [31:0] a;
        e.addr = addr; e.id = id; e.len = len; e.size = size; e.burst = burst; e.prot = prot;
        e.illegal = isIllegal(size, len, burst);
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            if (e.illegal) begin
                r.data = 32'h0;
                r.resp = 2'b10;
            end else begin
                m.addr = a;
                m.prot = prot;
                expMem.push_back(m);
                r.data = a ^ DATA_KEY;
                r.resp = (a == errAddr) ? 2'b10 : 2'b00;
            end
            r.id   = id;
            r.last = (b == int'(len));
            r.beat = b[7:0];
            expR.push_back(r);
            a = modelNext(a, size, len, burst);
        end
        fifoQ.push_back(e);
    endtask

    // Show-ahead AR FIFO model; a sampled pop takes effect at the following negedge.
    always @(negedge clk) begin
        if (reqCheck) begin
            checks++;
            if (mem_req !== reqCheckLegal || busy !== 1'b1)
                $display("[TB] FAIL pop_to_req: mem_req=%b busy=%b required mem_req=%b busy=1",
                         mem_req, busy, reqCheckLegal);
            if (mem_req !== reqCheckLegal || busy !== 1'b1) errors++;
            reqCheck = 1'b0;
        end
        if (popPending) begin
            if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            popPending = 1'b0;
        end
        if (fifoQ.size() > 0) begin
            fifo_empty = 1'b0;
            fifo_addr  = fifoQ[0].addr;
            fifo_id    = fifoQ[0].id;
            fifo_len   = fifoQ[0].len;
            fifo_size  = fifoQ[0].size;
            fifo_burst = fifoQ[0].burst;
            fifo_prot  = fifoQ[0].prot;
        end else begin
            fifo_empty = 1'b1;
        end
        #1;
        if (fifo_pop === 1'b1) begin
            popCount++;
            popCyc = cyc;
            checks++;
            if (fifo_empty !== 1'b0 || busy !== 1'b0 || fifoQ.size() == 0) begin
                $display("[TB] FAIL pop_context: fifo_empty=%b busy=%b required 0/0", fifo_empty, busy);
                errors++;
            end else begin
                popPending    = 1'b1;
                reqCheck      = 1'b1;
                reqCheckLegal = !fifoQ[0].illegal;
            end
            if (gapCheck) begin
                checks++;
                if (popCyc - lastHsCyc != 1) begin
                    $display("[TB] FAIL burst_gap: cycles=%0d required 1", popCyc - lastHsCyc);
                    errors++;
                end
                gapCheck = 1'b0;
            end
        end
    end

    // Memory model: acks after memLat wait cycles with data derived from the address.
    always @(negedge clk) begin
        mreq_t m;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (reset) begin
            waitCnt = 0;
        end else if (mem_req === 1'b1) begin
            if (waitCnt >= memLat) begin
                waitCnt = 0;
                memReqCount++;
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ DATA_KEY;
                mem_err   = (mem_addr == errAddr);
                checks++;
                if (expMem.size() == 0) begin
                    $display("[TB] FAIL mem_unexpected: addr=%h required no request", mem_addr);
                    errors++;
                end else begin
                    m = expMem.pop_front();
                    if (mem_addr !== m.addr || mem_prot !== m.prot) begin
                        $display("[TB] FAIL mem_addr: addr=%h prot=%b required addr=%h prot=%b",
                                 mem_addr, mem_prot, m.addr, m.prot);
                        errors++;
                    end
                end
            end else begin
                waitCnt++;
            end
        end else if (spuriousAck) begin
            mem_ack   = 1'b1;
            mem_err   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // R-channel monitor: drives RREADY (with optional stall) and pops the scoreboard.
    always @(negedge clk) begin
        rbeat_t e;
        if (reset) begin
            RREADY    = 1'b1;
            snapValid = 1'b0;
        end else begin
            if (RVALID === 1'b1) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    $display("[TB] FAIL req_in_resp: mem_req=%b required 0", mem_req);
                    errors++;
                end
            end
            if (RVALID === 1'b1 && stallLeft > 0 && beat_count == stallBeat) begin
                if (!snapValid) begin
                    snapData  = RDATA;
                    snapBeat  = beat_count;
                    snapResp  = RRESP;
                    snapValid = 1'b1;
                end else begin
                    checks++;
                    if (RDATA !== snapData || beat_count !== snapBeat || RRESP !== snapResp) begin
                        $display("[TB] FAIL stall_hold: data=%h beat=%0d resp=%b required %h %0d %b",
                                 RDATA, beat_count, RRESP, snapData, snapBeat, snapResp);
                        errors++;
                    end
                end
                RREADY = 1'b0;
                stallLeft--;
            end else begin
                RREADY = 1'b1;
            end
            if (RVALID === 1'b1 && RREADY === 1'b1) begin
                checks++;
                if (expR.size() == 0) begin
                    $display("[TB] FAIL r_unexpected: data=%h id=%0d required no beat", RDATA, RID);
                    errors++;
                end else begin
                    e = expR.pop_front();
                    if (RDATA !== e.data || RRESP !== e.resp || RID !== e.id ||
                        RLAST !== e.last || beat_count !== e.beat) begin
                        $display("[TB] FAIL r_beat: data=%h resp=%b id=%0d last=%b beat=%0d required %h %b %0d %b %0d",
                                 RDATA, RRESP, RID, RLAST, beat_count,
                                 e.data, e.resp, e.id, e.last, e.beat);
                        errors++;
                    end
                end
                if (RLAST === 1'b1) lastHsCyc = cyc;
                snapValid = 1'b0;
            end
        end
    end

    task automatic waitIdle(input int maxCyc, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxCyc) begin
            @(negedge clk);
            #2;
            n++;
            done = (expR.size() == 0) && (fifoQ.size() == 0) && !popPending && (busy === 1'b0);
        end
        checks++;
        if (!done || expMem.size() != 0) begin
            $display("[TB] FAIL %s_timeout: beats_left=%0d mem_left=%0d busy=%b required 0 0 0",
                     name, expR.size(), expMem.size(), busy);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RREADY = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({fifo_pop, mem_req, RVALID, RLAST, busy} !== 5'b0 || mem_addr !== 32'h0 ||
            mem_prot !== 3'h0 || RDATA !== 32'h0 || RRESP !== 2'b00 || RID !== 6'h0 ||
            beat_count !== 8'h0) begin
            $display("[TB] FAIL reset_values: ctl=%b addr=%h data=%h id=%0d beat=%0d required all zero",
                     {fifo_pop, mem_req, RVALID, RLAST, busy}, mem_addr, RDATA, RID, beat_count);
            errors++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || fifo_pop !== 1'b0) begin
            $display("[TB] FAIL reset_idle: busy=%b pop=%b required 0 0", busy, fifo_pop);
            errors++;
        end
    endtask

    task automatic test_incr();
        int base;
        base = memReqCount;
        memLat = 0;
        pushEntry(32'h0000_1000, 6'd3, 8'd3, 3'd2, BURST_INCR, 3'b010);
        waitIdle(100, "incr");
        checks++;
        if (memReqCount - base != 4) begin
            $display("[TB] FAIL incr_reqs: count=%0d required 4", memReqCount - base);
            errors++;
        end
        memLat = 2;
        pushEntry(32'hFFFF_FFFC, 6'd4, 8'd1, 3'd2, BURST_INCR, 3'b001);
        waitIdle(100, "incr_rollover");
        memLat = 0;
    endtask

    task automatic test_wrap();
        pushEntry(32'h0000_2008, 6'd6, 8'd3, 3'd2, BURST_WRAP, 3'b000);
        waitIdle(100, "wrap4");
        pushEntry(32'h0000_5006, 6'd7, 8'd7, 3'd1, BURST_WRAP, 3'b100);
        waitIdle(100, "wrap8");
        pushEntry(32'h0000_600D, 6'd10, 8'd15, 3'd0, BURST_WRAP, 3'b011);
        waitIdle(200, "wrap16");
    endtask

    task automatic test_fixed_stall();
        int base;
        base = memReqCount;
        memLat = 1;
        stallBeat = 1;
        stallLeft = 3;
        spuriousAck = 1'b1;
        pushEntry(32'h0000_3000, 6'd11, 8'd2, 3'd2, BURST_FIXED, 3'b110);
        waitIdle(100, "fixed_stall");
        checks++;
        if (memReqCount - base != 3 || stallLeft != 0) begin
            $display("[TB] FAIL fixed_reqs: count=%0d stall_left=%0d required 3 0",
                     memReqCount - base, stallLeft);
            errors++;
        end
        spuriousAck = 1'b0;
        stallBeat = -1;
        memLat = 0;
    endtask

    task automatic test_error();
        int base;
        base = memReqCount;
        pushEntry(32'h0000_7000, 6'd12, 8'd1, 3'd2, 2'b11, 3'b000);
        pushEntry(32'h0000_7100, 6'd13, 8'd2, 3'd2, BURST_WRAP, 3'b000);
        pushEntry(32'h0000_7200, 6'd14, 8'd0, 3'd3, BURST_INCR, 3'b000);
        waitIdle(100, "illegal");
        checks++;
        if (memReqCount != base) begin
            $display("[TB] FAIL illegal_reqs: count=%0d required 0", memReqCount - base);
            errors++;
        end
        errAddr = 32'h0000_4008;
        pushEntry(32'h0000_4000, 6'd8, 8'd3, 3'd2, BURST_INCR, 3'b000);
        waitIdle(100, "mem_err");
        errAddr = 32'hFFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        base = popCount;
        pushEntry(32'h0000_9000, 6'd5, 8'd0, 3'd2, BURST_INCR, 3'b000);
        pushEntry(32'h0000_9100, 6'd9, 8'd1, 3'd2, BURST_INCR, 3'b000);
        n = 0;
        while (popCount == base && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        gapCheck = 1'b1;
        waitIdle(100, "back_to_back");
        checks++;
        if (popCount - base != 2 || gapCheck) begin
            $display("[TB] FAIL pop_count: pops=%0d gap_pending=%b required 2 0", popCount - base, gapCheck);
            errors++;
        end
        gapCheck = 1'b0;
        pushEntry(32'h0001_0000, 6'd15, 8'd255, 3'd2, BURST_INCR, 3'b101);
        waitIdle(2000, "len255");
    endtask

    task automatic test_reset_mid();
        int n;
        int base;
        bit found;
        memLat = 20;
        pushEntry(32'h0000_8000, 6'd2, 8'd3, 3'd2, BURST_INCR, 3'b111);
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            #2;
            n++;
            found = (mem_req === 1'b1) && (beat_count == 8'd2);
        end
        checks++;
        if (!found) begin
            $display("[TB] FAIL reset_mid_reach: beat=%0d mem_req=%b required 2 1", beat_count, mem_req);
            errors++;
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({fifo_pop, mem_req, RVALID, RLAST, busy} !== 5'b0 || mem_addr !== 32'h0 ||
            mem_prot !== 3'h0 || RDATA !== 32'h0 || RRESP !== 2'b00 || RID !== 6'h0 ||
            beat_count !== 8'h0) begin
            $display("[TB] FAIL reset_mid_values: ctl=%b addr=%h data=%h id=%0d beat=%0d required all zero",
                     {fifo_pop, mem_req, RVALID, RLAST, busy}, mem_addr, RDATA, RID, beat_count);
            errors++;
        end
        expR.delete();
        expMem.delete();
        memLat = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base = popCount;
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || fifo_pop !== 1'b0 || popCount != base || RVALID !== 1'b0) begin
            $display("[TB] FAIL reset_mid_idle: busy=%b pop=%b pops=%0d rvalid=%b required 0 0 0 0",
                     busy, fifo_pop, popCount - base, RVALID);
            errors++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        RREADY = 1'b1;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
